tile_packer: RTL and testbench
==============================

TILE_PACKER -- requirements
Module: tile_packer

Interface
REQ-001 SHALL have parameter ROWS, default 3, number of tile rows (>=1).
REQ-002 SHALL have parameter COLS, default 4, number of records per row (>=1).
REQ-003 SHALL have parameter REC_W, default 3, record width in bits (>=1); for REC_W=3 the bits are fields a,b,c with a at the MSB.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port flush  input  1  synchronous abort of the current tile.
REQ-007 SHALL have port in_valid  input  1  record present.
REQ-008 SHALL have port in_ready  output  1  block accepts a record.
REQ-009 SHALL have port in_rec  input  REC_W  incoming record.
REQ-010 SHALL have port out_valid  output  1  complete tile held.
REQ-011 SHALL have port out_ready  input  1  consumer takes the tile.
REQ-012 SHALL have port out_tile  output  ROWS*COLS*REC_W  packed tile, viewed as [ROWS-1:0][COLS-1:0] records.
REQ-013 SHALL have port fill_cnt  output  clog2(ROWS*COLS+1)  records captured in the current tile.

Function
REQ-014 SHALL implement a two-state FSM: FILL (in_ready=1, out_valid=0) and HOLD (in_ready=0, out_valid=1); in_ready and out_valid SHALL be decoded from state only.
REQ-015 SHALL accept a record on each cycle with in_valid && in_ready, writing it to element [r][c] at bits (r*COLS+c)*REC_W +: REC_W.
REQ-016 SHALL fill in row-major order: c increments from 0 to COLS-1, then wraps to 0 with r incremented; r wraps to 0 after ROWS-1.
REQ-017 SHALL increment fill_cnt by one per accepted record.
REQ-018 SHALL move FILL->HOLD on the cycle the ROWS*COLS-th record is accepted; out_valid SHALL be 1 on the next cycle, with out_tile complete and fill_cnt = ROWS*COLS.
REQ-019 SHALL keep out_tile and fill_cnt stable in HOLD until handshake.
REQ-020 SHALL move HOLD->FILL on out_valid && out_ready, clearing r, c and fill_cnt to 0 and out_tile to all zeros; a new record SHALL be accepted no earlier than the following cycle.
REQ-021 SHALL give flush priority over every other event: on a flush cycle the state goes to FILL, counters and out_tile are cleared, and any simultaneous input record or output handshake is discarded.
REQ-022 SHALL ignore in_rec whenever in_ready=0 or in_valid=0.
REQ-023 SHALL hold out_tile bits of unwritten elements at 0 during a partial fill.

Reset
REQ-024 SHALL, while rst_n=0, force state FILL, r=c=0, fill_cnt=0, out_tile=0, out_valid=0 and in_ready=1, regardless of clk.
REQ-025 SHALL abandon a partial or held tile when reset asserts mid-operation, and resume with element [0][0] after release.

Configuration
REQ-026 SHALL support macro TILE_PACKER_PARITY_EN; when defined, an output out_parity (1 bit) SHALL exist, equal to the XOR of all out_tile bits, registered with the tile and 0 on reset or flush.
REQ-027 SHALL, without TILE_PACKER_PARITY_EN, have no out_parity port and no parity logic.

Verification (ROWS=2, COLS=2, REC_W=3 unless stated)
REQ-028 SHALL cover basic fill: send 3'b101, 3'b010, 3'b111, 3'b000 back-to-back with out_ready=0 -> out_valid rises one cycle after the 4th accept; out_tile=12'h1D5; fill_cnt=4; in_ready=0; with PARITY_EN out_parity=0.
REQ-029 SHALL cover backpressure: hold out_ready=0 for 10 cycles with in_valid=1 -> out_tile stays 12'h1D5 and no record is accepted; raise out_ready -> next cycle out_valid=0, out_tile=0, in_ready=1.
REQ-030 SHALL cover gapped input: toggle in_valid randomly over 4 records -> out_tile equals the back-to-back result and fill_cnt steps 0..4.
REQ-031 SHALL cover flush: flush with in_valid=1 after 2 records -> that record is dropped, fill_cnt=0, out_tile=0; the next 4 records produce a correct tile; flush in HOLD together with out_ready=1 -> tile discarded, out_valid=0.
REQ-032 SHALL cover reset: assert rst_n=0 asynchronously mid-fill (fill_cnt=3) -> all outputs reach reset values without a clock edge.
REQ-033 SHALL cover defaults: ROWS=3, COLS=4, REC_W=3, with records fed as all-ones for row 0, alternating 101/010 for row 1 and zeros for row 2 -> row 0 slice (bits 11:0) is 12'hFFF, out_tile bits 35:24 are 12'h000.

Source files
------------

// File: rtl/tile_packer.sv
// Packs a stream of REC_W-bit records into a ROWS x COLS tile, row-major, and holds it until taken.
// Define TILE_PACKER_PARITY_EN to add the out_parity output (XOR of all out_tile bits).
module tile_packer #(
  parameter int unsigned ROWS  = 3,
  parameter int unsigned COLS  = 4,
  parameter int unsigned REC_W = 3
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              flush,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [REC_W-1:0]                  in_rec,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [ROWS*COLS*REC_W-1:0]        out_tile,
  output logic [$clog2(ROWS*COLS+1)-1:0]    fill_cnt
`ifdef TILE_PACKER_PARITY_EN
  ,
  output logic                              out_parity
`endif
);

  localparam int unsigned NREC = ROWS * COLS;
  localparam int unsigned TW   = NREC * REC_W;
  localparam int unsigned CW   = $clog2(NREC + 1);
  localparam int unsigned RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned KW   = (COLS > 1) ? $clog2(COLS) : 1;

  typedef enum logic [0:0] {StFill, StHold} state_e;

  state_e          state_q, state_d;
  logic [RW-1:0]   r_q, r_d;
  logic [KW-1:0]   c_q, c_d;
  logic [CW-1:0]   fill_q, fill_d;
  logic [TW-1:0]   tile_q, tile_d;
  int unsigned     wr_idx;

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    c_d     = c_q;
    fill_d  = fill_q;
    tile_d  = tile_q;
    wr_idx  = int'(r_q) * COLS + int'(c_q);

    if (flush) begin
      // Abort wins over any concurrent accept or handshake.
      state_d = StFill;
      r_d     = '0;
      c_d     = '0;
      fill_d  = '0;
      tile_d  = '0;
    end else begin
      unique case (state_q)
        StFill: begin
          if (in_valid) begin
            for (int unsigned i = 0; i < NREC; i++) begin
              if (i == wr_idx) tile_d[i*REC_W +: REC_W] = in_rec;
            end
            fill_d = fill_q + 1'b1;
            if (c_q == KW'(COLS - 1)) begin
              c_d = '0;
              r_d = (r_q == RW'(ROWS - 1)) ? '0 : r_q + 1'b1;
            end else begin
              c_d = c_q + 1'b1;
            end
            if (fill_q == CW'(NREC - 1)) state_d = StHold;
          end
        end
        StHold: begin
          if (out_ready) begin
            state_d = StFill;
            r_d     = '0;
            c_d     = '0;
            fill_d  = '0;
            tile_d  = '0;
          end
        end
        default: state_d = StFill;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StFill;
      r_q     <= '0;
      c_q     <= '0;
      fill_q  <= '0;
      tile_q  <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      c_q     <= c_d;
      fill_q  <= fill_d;
      tile_q  <= tile_d;
    end
  end

  assign in_ready  = (state_q == StFill);
  assign out_valid = (state_q == StHold);
  assign out_tile  = tile_q;
  assign fill_cnt  = fill_q;

`ifdef TILE_PACKER_PARITY_EN
  logic parity_q;

  // Tracks the tile register; flush/handshake zero tile_d so parity follows to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) parity_q <= 1'b0;
    else        parity_q <= ^tile_d;
  end

  assign out_parity = parity_q;
`endif

endmodule

// File: tb/tb_tile_packer.sv
// Scoreboard bench for tile_packer: 2x2x3 instance for the main scenarios, default instance for
// the 3x4 row-slice check.
module tb_tile_packer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // 2x2, REC_W=3 instance
  logic        flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [2:0]  in_rec = '0;
  logic        in_ready, out_valid;
  logic [11:0] out_tile;
  logic [2:0]  fill_cnt;
`ifdef TILE_PACKER_PARITY_EN
  logic        out_parity;
`endif

  tile_packer #(.ROWS(2), .COLS(2), .REC_W(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_rec    (in_rec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_tile  (out_tile),
    .fill_cnt  (fill_cnt)
`ifdef TILE_PACKER_PARITY_EN
    ,
    .out_parity(out_parity)
`endif
  );

  // Default-parameter instance
  logic        b_flush = 1'b0, b_in_valid = 1'b0, b_out_ready = 1'b0;
  logic [2:0]  b_in_rec = '0;
  logic        b_in_ready, b_out_valid;
  logic [35:0] b_out_tile;
  logic [3:0]  b_fill_cnt;
`ifdef TILE_PACKER_PARITY_EN
  logic        b_out_parity;
`endif

  tile_packer dut_def (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (b_flush),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .in_rec    (b_in_rec),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .out_tile  (b_out_tile),
    .fill_cnt  (b_fill_cnt)
`ifdef TILE_PACKER_PARITY_EN
    ,
    .out_parity(b_out_parity)
`endif
  );

  int checks = 0;
  int failures = 0;

  logic [11:0] exp_tile_q[$];
  logic [2:0]  exp_cnt_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compare each newly presented tile against the scoreboard.
  logic prev_valid = 1'b0;
  always @(negedge clk) begin
    if (out_valid && !prev_valid) begin
      if (exp_tile_q.size() == 0) begin
        check("unexpected_tile", 64'(out_tile), 64'hDEAD);
      end else begin
        logic [11:0] et;
        logic [2:0]  ec;
        et = exp_tile_q.pop_front();
        ec = exp_cnt_q.pop_front();
        check("sb_tile", 64'(out_tile), 64'(et));
        check("sb_fill_cnt", 64'(fill_cnt), 64'(ec));
        check("sb_in_ready", 64'(in_ready), 64'd0);
`ifdef TILE_PACKER_PARITY_EN
        check("sb_parity", 64'(out_parity), 64'(^et));
`endif
      end
    end
    prev_valid <= out_valid;
  end

  // Drive one record after `gap` idle cycles; returns #1 after the accepting edge.
  task automatic send(input logic [2:0] rec, input int gap);
    in_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_rec   = rec;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [2:0] recs [4];
    int         gaps [4];
    recs = '{3'b101, 3'b010, 3'b111, 3'b000};
    gaps = '{2, 0, 3, 1};

    #12;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_tile", 64'(out_tile), 64'd0);
    check("rst_fill", 64'(fill_cnt), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic back-to-back fill
    exp_tile_q.push_back(12'h1D5);
    exp_cnt_q.push_back(3'd4);
    for (int i = 0; i < 4; i++) send(recs[i], 0);
    check("basic_out_valid", 64'(out_valid), 64'd1);
    check("basic_in_ready", 64'(in_ready), 64'd0);

    // Backpressure: in_valid held high while in HOLD
    in_valid = 1'b1;
    in_rec   = 3'b011;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_tile", 64'(out_tile), 64'h1D5);
      check("bp_fill", 64'(fill_cnt), 64'd4);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    handshake();
    check("hs_out_valid", 64'(out_valid), 64'd0);
    check("hs_tile", 64'(out_tile), 64'd0);
    check("hs_in_ready", 64'(in_ready), 64'd1);
    check("hs_fill", 64'(fill_cnt), 64'd0);

    // Gapped input
    exp_tile_q.push_back(12'h1D5);
    exp_cnt_q.push_back(3'd4);
    for (int i = 0; i < 4; i++) begin
      send(recs[i], gaps[i]);
      check("gap_fill_step", 64'(fill_cnt), 64'(i + 1));
    end
    handshake();

    // Flush after two records with a record offered on the flush cycle
    send(3'b101, 0);
    send(3'b010, 0);
    in_valid = 1'b1;
    in_rec   = 3'b111;
    flush    = 1'b1;
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_fill", 64'(fill_cnt), 64'd0);
    check("flush_tile", 64'(out_tile), 64'd0);
    check("flush_in_ready", 64'(in_ready), 64'd1);
    exp_tile_q.push_back(12'h3A3);
    exp_cnt_q.push_back(3'd4);
    send(3'b011, 0);
    send(3'b100, 0);
    send(3'b110, 0);
    send(3'b001, 0);
    // Flush in HOLD together with out_ready
    flush     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    flush     = 1'b0;
    out_ready = 1'b0;
    check("flush_hold_valid", 64'(out_valid), 64'd0);
    check("flush_hold_tile", 64'(out_tile), 64'd0);

    // Asynchronous reset mid-fill
    send(3'b101, 0);
    send(3'b010, 0);
    send(3'b111, 0);
    check("pre_rst_fill", 64'(fill_cnt), 64'd3);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_fill", 64'(fill_cnt), 64'd0);
    check("async_rst_tile", 64'(out_tile), 64'd0);
    check("async_rst_valid", 64'(out_valid), 64'd0);
    check("async_rst_ready", 64'(in_ready), 64'd1);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    exp_tile_q.push_back(12'h1D5);
    exp_cnt_q.push_back(3'd4);
    for (int i = 0; i < 4; i++) send(recs[i], 0);
    handshake();
    check("sb_drained", 64'(exp_tile_q.size()), 64'd0);

    // Default geometry: row 0 ones, row 1 alternating 101/010, row 2 zeros
    for (int i = 0; i < 12; i++) begin
      b_in_valid = 1'b1;
      if (i < 4)      b_in_rec = 3'b111;
      else if (i < 8) b_in_rec = (i % 2 == 0) ? 3'b101 : 3'b010;
      else            b_in_rec = 3'b000;
      @(posedge clk);
      #1;
    end
    b_in_valid = 1'b0;
    check("def_valid", 64'(b_out_valid), 64'd1);
    check("def_row0", 64'(b_out_tile[11:0]), 64'hFFF);
    check("def_row1", 64'(b_out_tile[23:12]), 64'h555);
    check("def_row2", 64'(b_out_tile[35:24]), 64'h000);
    check("def_fill", 64'(b_fill_cnt), 64'd12);

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
